// File: rtl/mem_arb_pkg.sv
// Constants and types shared by the data-RAM arbiter, its grant generator and the RAM.
package mem_arb_pkg;

  localparam int NUM_PORTS = 2;
  localparam int DEF_LEN   = 1024;
  localparam int DEF_AW    = 32;
  localparam int DEF_DW    = 32;

  typedef logic port_idx_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_M0   = 2'b01,
    GNT_M1   = 2'b10
  } gnt_t;

  // On a tie the port that did not win last time is chosen; otherwise the lone requester.
  function automatic port_idx_t rr_pick(input logic [NUM_PORTS-1:0] req, input port_idx_t last);
    if (req == 2'b11) begin
      return ~last;
    end
    return req[1] & ~req[0];
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the data-RAM arbiter: request/address/data in, grant/response out.
interface ram_arbiter_if import mem_arb_pkg::*; #(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);

  logic          req;
  logic          we;
  logic [AW-1:0] a;
  logic [DW-1:0] d;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          err;

  modport master (
    output req, we, a, d,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, a, d,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant generator with a registered last-winner pointer.
module rr_arb2 import mem_arb_pkg::*; (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic                 i_accept,
  output logic [NUM_PORTS-1:0] o_gnt,
  output port_idx_t            o_last
);

  port_idx_t r_last;
  port_idx_t w_pick;

  always_comb begin
    w_pick = rr_pick(i_req, r_last);
    o_gnt  = '0;
    if (!i_rst && (i_req != '0)) begin
      o_gnt[w_pick] = 1'b1;
    end
  end

  // Reset favours M0 on the first conflict by pretending M1 won last.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= 1'b1;
    end else if (i_accept) begin
      r_last <= w_pick;
    end
  end

  assign o_last = r_last;

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin sharing of the single-port data RAM between CPU (m0) and DMA (m1) requesters.
// Define ARB_PERF_EN to add per-port grant counters and a conflict-cycle counter.
module ram_arbiter import mem_arb_pkg::*; #(
  parameter int LEN = DEF_LEN,
  parameter int AW  = DEF_AW,
  parameter int DW  = DEF_DW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  ram_arbiter_if.slave  m0,
  ram_arbiter_if.slave  m1,
  output logic [AW-1:0] o_ram_a,
  output logic [DW-1:0] o_ram_d,
  output logic          o_ram_we,
  input  logic [DW-1:0] i_ram_q
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]   o_perf_gnt0,
  output logic [31:0]   o_perf_gnt1,
  output logic [31:0]   o_perf_conflict
`endif
);

  localparam logic [AW-1:0] LEN_A = AW'(LEN);

  logic [NUM_PORTS-1:0] w_req;
  logic [NUM_PORTS-1:0] w_we;
  logic [NUM_PORTS-1:0] w_gnt;
  logic [AW-1:0]        w_a [NUM_PORTS];
  logic [DW-1:0]        w_d [NUM_PORTS];
  port_idx_t            w_last;
  port_idx_t            w_sel;
  logic                 w_accept;
  logic                 w_in_range;

  assign w_req  = {m1.req, m0.req};
  assign w_we   = {m1.we,  m0.we};
  assign w_a[0] = m0.a;
  assign w_a[1] = m1.a;
  assign w_d[0] = m0.d;
  assign w_d[1] = m1.d;

  rr_arb2 u_rr_arb2 (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_req    (w_req),
    .i_accept (w_accept),
    .o_gnt    (w_gnt),
    .o_last   (w_last)
  );

  assign w_accept = |w_gnt;

  // Mux select follows the arbiter choice directly; it resolves to M0 when nobody requests.
  assign w_sel      = (&w_req) ? ~w_last : w_req[1];
  assign w_in_range = (w_a[w_sel] < LEN_A);
  assign o_ram_a    = w_a[w_sel];
  assign o_ram_d    = w_d[w_sel];
  assign o_ram_we   = w_accept & w_we[w_sel] & w_in_range;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_resp
    logic          r_rvalid;
    logic          r_err;
    logic [DW-1:0] r_rdata;

    // Writes leave read data untouched; rejected reads return zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_rvalid <= 1'b0;
        r_err    <= 1'b0;
        r_rdata  <= '0;
      end else begin
        r_rvalid <= w_gnt[gi];
        r_err    <= w_gnt[gi] & ~w_in_range;
        if (w_gnt[gi] && !w_we[gi]) begin
          r_rdata <= w_in_range ? i_ram_q : '0;
        end
      end
    end
  end

  assign m0.gnt    = w_gnt[0];
  assign m0.rvalid = g_resp[0].r_rvalid;
  assign m0.err    = g_resp[0].r_err;
  assign m0.rdata  = g_resp[0].r_rdata;
  assign m1.gnt    = w_gnt[1];
  assign m1.rvalid = g_resp[1].r_rvalid;
  assign m1.err    = g_resp[1].r_err;
  assign m1.rdata  = g_resp[1].r_rdata;

`ifdef ARB_PERF_EN
  logic [31:0] r_perf_gnt0;
  logic [31:0] r_perf_gnt1;
  logic [31:0] r_perf_conflict;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_perf_gnt0     <= '0;
      r_perf_gnt1     <= '0;
      r_perf_conflict <= '0;
    end else begin
      if (w_gnt[0]) begin
        r_perf_gnt0 <= r_perf_gnt0 + 32'd1;
      end
      if (w_gnt[1]) begin
        r_perf_gnt1 <= r_perf_gnt1 + 32'd1;
      end
      if (&w_req) begin
        r_perf_conflict <= r_perf_conflict + 32'd1;
      end
    end
  end

  assign o_perf_gnt0     = r_perf_gnt0;
  assign o_perf_gnt1     = r_perf_gnt1;
  assign o_perf_conflict = r_perf_conflict;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed vector table, reset corner case, random traffic.
module tb_ram_arbiter;
  import mem_arb_pkg::*;

  localparam int LEN = 1024;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
  ram_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();

  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d;
  logic [DW-1:0] ram_q;
  logic          ram_we;
`ifdef ARB_PERF_EN
  logic [31:0] perf_g0, perf_g1, perf_c;
`endif

  ram_arbiter #(.LEN(LEN), .AW(AW), .DW(DW)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .m0       (m0_if),
    .m1       (m1_if),
    .o_ram_a  (ram_a),
    .o_ram_d  (ram_d),
    .o_ram_we (ram_we),
    .i_ram_q  (ram_q)
`ifdef ARB_PERF_EN
    ,
    .o_perf_gnt0     (perf_g0),
    .o_perf_gnt1     (perf_g1),
    .o_perf_conflict (perf_c)
`endif
  );

  // Attached RAM: combinational read, write at the edge, address aliased to 10 bits.
  logic          init_mem;
  logic [DW-1:0] mem [LEN];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < LEN; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
    end else if (ram_we) begin
      mem[ram_a[9:0]] <= ram_d;
    end
  end
  assign ram_q = mem[ram_a[9:0]];

  // Reference model state
  logic [DW-1:0] ref_mem [LEN];
  int            last_m;
  logic [DW-1:0] exp_rdata [2];
  bit            rdata_known [2];
  int            exp_g0, exp_g1, exp_conf;
  int            checks, failures;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    last_m = 1;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    rdata_known[0] = 1'b1; rdata_known[1] = 1'b1;
    exp_g0 = 0; exp_g1 = 0; exp_conf = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    m0_if.req = 1'b1; m1_if.req = 1'b1;
    #1;
    chk("rst_gnt0", m0_if.gnt, 1'b0);
    chk("rst_gnt1", m1_if.gnt, 1'b0);
    @(posedge clk); #1;
    chk("rst_rvalid0", m0_if.rvalid, 1'b0);
    chk("rst_rvalid1", m1_if.rvalid, 1'b0);
    chk("rst_err0", m0_if.err, 1'b0);
    chk("rst_err1", m1_if.err, 1'b0);
    chk("rst_rdata0", m0_if.rdata, 32'h0);
    chk("rst_rdata1", m1_if.rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    m0_if.req = 1'b0; m1_if.req = 1'b0;
    model_reset();
  endtask

  // One bus cycle: drive, check grant/RAM pins before the edge, check responses after it.
  task automatic do_cycle(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                          input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                          output int gp, output logic [1:0] g_seen, output logic we_seen);
    logic        sw, in_rng;
    logic [31:0] sa, sd;
    @(negedge clk);
    m0_if.req = r0; m0_if.we = w0; m0_if.a = a0; m0_if.d = d0;
    m1_if.req = r1; m1_if.we = w1; m1_if.a = a1; m1_if.d = d1;
    #1;
    if (r0 && r1) gp = (last_m == 1) ? 0 : 1;
    else if (r0)  gp = 0;
    else if (r1)  gp = 1;
    else          gp = -1;
    sw = (gp == 1) ? w1 : w0;
    sa = (gp == 1) ? a1 : a0;
    sd = (gp == 1) ? d1 : d0;
    in_rng = (sa < 32'(LEN));
    g_seen  = {m1_if.gnt, m0_if.gnt};
    we_seen = ram_we;
    chk("gnt0", m0_if.gnt, gp == 0);
    chk("gnt1", m1_if.gnt, gp == 1);
    chk("ram_we", ram_we, (gp >= 0) && sw && in_rng);
    if (gp >= 0) begin
      chk("ram_a", ram_a, sa);
      if (sw) chk("ram_d", ram_d, sd);
    end
    if (r0 && r1) exp_conf++;
    if (gp >= 0) begin
      last_m = gp;
      if (gp == 0) exp_g0++; else exp_g1++;
      if (!sw) begin
        exp_rdata[gp]   = in_rng ? ref_mem[sa[9:0]] : 32'h0;
        rdata_known[gp] = 1'b1;
      end else if (in_rng) begin
        ref_mem[sa[9:0]] = sd;
      end else begin
        rdata_known[gp] = 1'b0;
      end
    end
    @(posedge clk); #1;
    chk("rvalid0", m0_if.rvalid, gp == 0);
    chk("rvalid1", m1_if.rvalid, gp == 1);
    chk("err0", m0_if.err, (gp == 0) && !in_rng);
    chk("err1", m1_if.err, (gp == 1) && !in_rng);
    if (rdata_known[0]) chk("rdata0", m0_if.rdata, exp_rdata[0]);
    if (rdata_known[1]) chk("rdata1", m1_if.rdata, exp_rdata[1]);
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 19);
    if (k == 0) return 32'hFFFF_FFFF;
    if (k == 1) return 32'(LEN) + 32'($urandom_range(0, 3));
    if (k == 2) return 32'(LEN - 1);
    return 32'($urandom_range(0, 15));
  endfunction

  typedef struct {
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic [1:0]  gnt;
    logic        ram_we;
    logic        rsp_err;
    logic        chk_rdata;
    logic [31:0] rsp_rdata;
  } vec_t;

  vec_t vt [12];

  initial begin : main
    int          gp;
    logic [1:0]  gs;
    logic        ws;
    logic        r0, r1;
    int          p;
    checks = 0; failures = 0;
    init_mem = 1'b1;
    for (int i = 0; i < LEN; i++) ref_mem[i] = 32'hA5A5_0000 | 32'(i);
    m0_if.req = 1'b0; m0_if.we = 1'b0; m0_if.a = '0; m0_if.d = '0;
    m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.a = '0; m1_if.d = '0;
    model_reset();
    do_reset();
    init_mem = 1'b0;

    //        r0 w0 a0              d0             r1 w1 a1              d1           gnt    we  err chk rdata
    vt[0]  = '{1, 0, 32'd1,          32'h0,         1, 0, 32'd2,          32'h0,       2'b01, 0, 0, 1, 32'hA5A5_0001};
    vt[1]  = '{1, 0, 32'd1,          32'h0,         1, 0, 32'd2,          32'h0,       2'b10, 0, 0, 1, 32'hA5A5_0002};
    vt[2]  = '{1, 0, 32'd1,          32'h0,         1, 0, 32'd2,          32'h0,       2'b01, 0, 0, 1, 32'hA5A5_0001};
    vt[3]  = '{1, 0, 32'd1,          32'h0,         1, 0, 32'd2,          32'h0,       2'b10, 0, 0, 1, 32'hA5A5_0002};
    vt[4]  = '{1, 1, 32'd5,          32'hDEADBEEF,  0, 0, 32'd0,          32'h0,       2'b01, 1, 0, 0, 32'h0};
    vt[5]  = '{1, 0, 32'd5,          32'h0,         0, 0, 32'd0,          32'h0,       2'b01, 0, 0, 1, 32'hDEADBEEF};
    vt[6]  = '{0, 0, 32'd0,          32'h0,         0, 0, 32'd0,          32'h0,       2'b00, 0, 0, 0, 32'h0};
    vt[7]  = '{0, 0, 32'd0,          32'h0,         1, 1, 32'd1024,       32'h0BAD,    2'b10, 0, 1, 0, 32'h0};
    vt[8]  = '{0, 0, 32'd0,          32'h0,         1, 0, 32'hFFFF_FFFF,  32'h0,       2'b10, 0, 1, 1, 32'h0};
    vt[9]  = '{1, 1, 32'd7,          32'h1234,      0, 0, 32'd0,          32'h0,       2'b01, 1, 0, 0, 32'h0};
    vt[10] = '{0, 0, 32'd0,          32'h0,         1, 0, 32'd7,          32'h0,       2'b10, 0, 0, 1, 32'h1234};
    vt[11] = '{0, 0, 32'd0,          32'h0,         0, 0, 32'd0,          32'h0,       2'b00, 0, 0, 0, 32'h0};

    for (int i = 0; i < 12; i++) begin
      do_cycle(vt[i].r0, vt[i].w0, vt[i].a0, vt[i].d0, vt[i].r1, vt[i].w1, vt[i].a1, vt[i].d1, gp, gs, ws);
      chk($sformatf("vec%0d_gnt", i), gs, vt[i].gnt);
      chk($sformatf("vec%0d_ram_we", i), ws, vt[i].ram_we);
      if (vt[i].gnt != 2'b00) begin
        p = vt[i].gnt[1] ? 1 : 0;
        chk($sformatf("vec%0d_err", i), (p == 1) ? m1_if.err : m0_if.err, vt[i].rsp_err);
        if (vt[i].chk_rdata)
          chk($sformatf("vec%0d_rdata", i), (p == 1) ? m1_if.rdata : m0_if.rdata, vt[i].rsp_rdata);
      end
    end
    chk("oor_write_no_alias", mem[0], 32'hA5A5_0000);

    // Reset while a read response is on the bus: it must vanish at once.
    do_cycle(1, 0, 32'd3, 32'h0, 0, 0, 32'd0, 32'h0, gp, gs, ws);
    #1;
    rst = 1'b1;
    m0_if.req = 1'b0;
    #1;
    chk("async_rst_rvalid0", m0_if.rvalid, 1'b0);
    chk("async_rst_rdata0", m0_if.rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    do_cycle(1, 0, 32'd1, 32'h0, 1, 0, 32'd2, 32'h0, gp, gs, ws);
    chk("post_rst_first_gnt", gs, 2'b01);

    // Random traffic; a request that lost stays asserted while its fields may change.
    r0 = 1'b0; r1 = 1'b0; gp = -1;
    for (int i = 0; i < 500; i++) begin
      if (!(r0 && gp != 0)) r0 = ($urandom_range(0, 3) != 0);
      if (!(r1 && gp != 1)) r1 = ($urandom_range(0, 3) != 0);
      do_cycle(r0, 1'($urandom_range(0, 1)), rand_addr(), $urandom(),
               r1, 1'($urandom_range(0, 1)), rand_addr(), $urandom(), gp, gs, ws);
    end

`ifdef ARB_PERF_EN
    chk("perf_gnt0_rand", perf_g0, exp_g0);
    chk("perf_gnt1_rand", perf_g1, exp_g1);
    chk("perf_conf_rand", perf_c, exp_conf);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      do_cycle(1, 0, 32'd1, 32'h0, 1, 0, 32'd2, 32'h0, gp, gs, ws);
    end
    chk("perf_gnt0_10", perf_g0, 32'd5);
    chk("perf_gnt1_10", perf_g1, 32'd5);
    chk("perf_conf_10", perf_c, 32'd10);
    do_reset();
    chk("perf_gnt0_rst", perf_g0, 32'd0);
    chk("perf_gnt1_rst", perf_g1, 32'd0);
    chk("perf_conf_rst", perf_c, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
